alu_datapath: RTL
=================

# alu_datapath

Accumulator, B register, ALU, flag register and output register of the 8-bit microprocessor. It sits directly downstream of the control sequencer and consumes its active-low load strobes, output enables and operation selects. It exchanges 8-bit values with the shared W-bus and drives the output port. Bus drive is modelled as a value plus an enable; the top level performs the bus multiplexing, with no tristates.

## Interface
- WIDTH, 8, datapath width; must be ≥ 4.
- clk  in  1  rising-edge clock.
- clr  in  1  reset, asynchronous and active-high; clears every register in the block.
- bus_in  in  WIDTH  current W-bus value.
- low_ld_acc, low_ld_b_reg, low_ld_out_reg  in  1 each  active-low load strobes.
- acc_out_en  in  1  drive the accumulator onto the bus.
- subadd_out_en  in  1  drive the ALU result onto the bus.
- sub_add, and_ratna, or_ratna, xor_ratna, cmp_ratna  in  1 each  operation selects; none asserted means ADD.
- low_halt  in  1  active-low halt.
- bus_out  out  WIDTH  value this block drives.
- bus_oe  out  1  this block is driving the bus.
- acc_q, b_q  out  WIDTH  register contents, for debug.
- out_value  out  WIDTH  output-register contents.
- flag_c, flag_z, flag_n, flag_v  out  1 each  registered flags.
- bus_conflict  out  1  sticky error flag.

## Operation
- **Op priority:** cmp > xor > and > or > sub > add.
- **Result r:**
  - ADD: A+B.
  - SUB: A+~B+1.
  - AND, OR, XOR: bitwise on A and B.
  - CMP: r = A, and the flags are computed from A−B.
- **Flags:**
  - C = carry out of bit WIDTH−1. For SUB/CMP, C=1 means A ≥ B unsigned.
  - Z = (arith result == 0).
  - N = MSB of the arith result.
  - V = signed overflow.
  - For logic ops, C = V = 0 and Z/N come from r.
- **Bus drive:**
  - bus_oe = acc_out_en | subadd_out_en.
  - bus_out = A when acc_out_en, else r.
  - bus_out = 0 when bus_oe = 0.
  - If both enables are high, A wins.
- **Register loads:** on a rising edge with low_halt = 1:
  - A ← bus_in if low_ld_acc = 0.
  - B ← bus_in if low_ld_b_reg = 0.
  - OUT ← bus_in if low_ld_out_reg = 0.
  - Flags ← computed flags if subadd_out_en = 1.
- **CMP:** acc reload is harmless because r = A. A is unchanged.
- **bus_conflict:** set on any edge where acc_out_en & subadd_out_en. Cleared only by clr.
- **Halt:** low_halt = 0 suppresses every load, flag update and bus_conflict set. Outputs hold their values; bus_oe still follows the enables.
- **Reset:** clr clears A, B, OUT, all flags and bus_conflict to 0 immediately, without waiting for clk, including mid-operation. bus_out/bus_oe are then 0 unless the enables are high.

## Timing
- bus_out/bus_oe are combinational from the enables, selects, A and B, with zero latency.
- A register loaded from the bus is visible on acc_q/b_q/out_value one cycle after the load edge.
- ALU writeback takes one edge: on the same edge, subadd_out_en = 1 and low_ld_acc = 0 load r into A and update the flags.
- A load and a bus drive of the same register on the same edge load the old value, with no hazard. Example: acc_out_en with low_ld_acc.
- clr asserted on a clock edge dominates; its deassertion takes effect on the next edge.

## Configuration
- **ALU_FLAGS_EN defined:** flag register present, behaving as described above.
- **ALU_FLAGS_EN undefined:**
  - flag_c/z/n/v are tied 0.
  - CMP still yields r = A and leaves A unchanged.
  - No flag flip-flops are synthesised.

## Structure
- **alu_pkg:**
  - WIDTH default.
  - alu_op_e enumeration (ADD, SUB, AND, OR, XOR, CMP).
  - alu_flags_t struct {c, z, n, v}.
  - Priority-decode function from the select lines to alu_op_e.
- **Sub-module alu_core:** purely combinational. Inputs: A, B, alu_op_e. Outputs: r and alu_flags_t.
- **alu_datapath:** owns all registers, bus muxing, halt and conflict logic.

## Test plan
- **Async reset:** load A=0x5A, then pulse clr between edges -> acc_q=0 immediately, all flags 0, bus_conflict=0.
- **ADD with overflow:** A=0x7F, B=0x01, ADD writeback -> A=0x80, C=0, Z=0, N=1, V=1. Then A=0xFF, B=0x01 -> A=0x00, C=1, Z=1, V=0.
- **SUB and CMP:** A=0x05, B=0x07, SUB -> A=0xFE, C=0, N=1. Then A=0x09, B=0x09, CMP -> A stays 0x09, Z=1, C=1.
- **Logic and priority:** A=0xF0, B=0x3C with xor_ratna and sub_add both high -> A=0xCC, C=0, V=0.
- **Halt:** low_halt=0 with low_ld_acc=0, bus_in=0x11 for 3 cycles -> A unchanged, flags unchanged. Releasing halt allows the load on the next edge.
- **Conflict and output:** acc_out_en and subadd_out_en both high -> bus_out=A, bus_conflict=1, and it stays set. Then low_ld_out_reg=0 with acc_out_en, A=0x42 -> out_value=0x42 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the accumulator/ALU datapath: operation encoding, flag bundle and select decode.
// Optional flag register is enabled with the ALU_FLAGS_EN macro.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_CMP
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  // Sequencer may raise several selects at once; the highest-priority one wins.
  function automatic alu_op_e alu_decode(input logic sub_add, input logic and_ratna,
                                         input logic or_ratna, input logic xor_ratna,
                                         input logic cmp_ratna);
    alu_op_e op;
    if (cmp_ratna)      op = ALU_CMP;
    else if (xor_ratna) op = ALU_XOR;
    else if (and_ratna) op = ALU_AND;
    else if (or_ratna)  op = ALU_OR;
    else if (sub_add)   op = ALU_SUB;
    else                op = ALU_ADD;
    return op;
  endfunction

endpackage

// File: rtl/alu_datapath_if.sv
// Control strobes, W-bus exchange and status outputs between the sequencer and the ALU datapath.
interface alu_datapath_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] bus_in;
  logic             low_ld_acc;
  logic             low_ld_b_reg;
  logic             low_ld_out_reg;
  logic             acc_out_en;
  logic             subadd_out_en;
  logic             sub_add;
  logic             and_ratna;
  logic             or_ratna;
  logic             xor_ratna;
  logic             cmp_ratna;
  logic             low_halt;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_value;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             bus_conflict;

  modport master (
    output bus_in, low_ld_acc, low_ld_b_reg, low_ld_out_reg, acc_out_en, subadd_out_en,
           sub_add, and_ratna, or_ratna, xor_ratna, cmp_ratna, low_halt,
    input  bus_out, bus_oe, acc_q, b_q, out_value, flag_c, flag_z, flag_n, flag_v, bus_conflict
  );

  modport slave (
    input  bus_in, low_ld_acc, low_ld_b_reg, low_ld_out_reg, acc_out_en, subadd_out_en,
           sub_add, and_ratna, or_ratna, xor_ratna, cmp_ratna, low_halt,
    output bus_out, bus_oe, acc_q, b_q, out_value, flag_c, flag_z, flag_n, flag_v, bus_conflict
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: one shared adder serves ADD, SUB and CMP; flags exist only with ALU_FLAGS_EN.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] r
`ifdef ALU_FLAGS_EN
  ,
  output alu_flags_t       flags
`endif
);

`ifdef ALU_FLAGS_EN
  localparam int SUM_W = WIDTH + 1;
`else
  localparam int SUM_W = WIDTH;
`endif

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [SUM_W-1:0] sum;

  assign sub_mode = (op == ALU_SUB) || (op == ALU_CMP);
  assign b_eff    = sub_mode ? ~b : b;
  assign sum      = SUM_W'(a) + SUM_W'(b_eff) + SUM_W'(sub_mode);

  always_comb begin
    r = sum[WIDTH-1:0];
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_CMP: r = a;
      default: r = sum[WIDTH-1:0];
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic logic_op;
  assign logic_op = (op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR);

  always_comb begin
    flags = '0;
    if (logic_op) begin
      flags.z = (r == '0);
      flags.n = r[WIDTH-1];
    end else begin
      flags.c = sum[WIDTH];
      flags.z = (sum[WIDTH-1:0] == '0);
      flags.n = sum[WIDTH-1];
      // Overflow: operands of equal sign as seen by the adder, result sign flipped.
      flags.v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end
`endif

endmodule

// File: rtl/alu_datapath.sv
// Accumulator, B, output and flag registers plus W-bus drive for the 8-bit CPU (WIDTH >= 4).
// Flag register is built only when ALU_FLAGS_EN is defined; otherwise flags read as 0.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic         clk,
  input logic         clr,
  alu_datapath_if.slave dp
);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_reg;
  logic             conflict_reg;
  logic [WIDTH-1:0] alu_r;
  alu_op_e          op;

  assign op = alu_decode(dp.sub_add, dp.and_ratna, dp.or_ratna, dp.xor_ratna, dp.cmp_ratna);

`ifdef ALU_FLAGS_EN
  alu_flags_t core_flags;
  alu_flags_t flags_reg;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a  (acc_reg),
    .b  (b_reg),
    .op (op),
    .r  (alu_r)
`ifdef ALU_FLAGS_EN
    ,
    .flags(core_flags)
`endif
  );

  // Accumulator wins when both drivers are enabled; the conflict flag records it.
  assign dp.bus_oe = dp.acc_out_en | dp.subadd_out_en;

  always_comb begin
    dp.bus_out = '0;
    if (dp.acc_out_en)         dp.bus_out = acc_reg;
    else if (dp.subadd_out_en) dp.bus_out = alu_r;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc_reg      <= '0;
      b_reg        <= '0;
      out_reg      <= '0;
      conflict_reg <= 1'b0;
    end else if (dp.low_halt) begin
      if (!dp.low_ld_acc)                     acc_reg      <= dp.bus_in;
      if (!dp.low_ld_b_reg)                   b_reg        <= dp.bus_in;
      if (!dp.low_ld_out_reg)                 out_reg      <= dp.bus_in;
      if (dp.acc_out_en && dp.subadd_out_en)  conflict_reg <= 1'b1;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                   flags_reg <= '0;
    else if (dp.low_halt && dp.subadd_out_en)  flags_reg <= core_flags;
  end

  assign dp.flag_c = flags_reg.c;
  assign dp.flag_z = flags_reg.z;
  assign dp.flag_n = flags_reg.n;
  assign dp.flag_v = flags_reg.v;
`else
  assign dp.flag_c = 1'b0;
  assign dp.flag_z = 1'b0;
  assign dp.flag_n = 1'b0;
  assign dp.flag_v = 1'b0;
`endif

  assign dp.acc_q        = acc_reg;
  assign dp.b_q          = b_reg;
  assign dp.out_value    = out_reg;
  assign dp.bus_conflict = conflict_reg;

endmodule
